// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turns one-hot keypad presses into a BCD digit entry with commit, try count and lockout
module keypad_entry_ctrl #(
    parameter int NDIG      = 3,
    parameter int MAX_TRIES = 9
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic [15:0]         key,
    output logic [4*NDIG-1:0]   data,
    output logic [1:0]          digit_cnt,
    output logic [3:0]          cur_digit,
    output logic [3:0]          tries,
    output logic                commit,
    output logic [4*NDIG-1:0]   guess,
    output logic                locked
);

    localparam logic [1:0] NDIG_C = 2'(NDIG);
    localparam logic [3:0] MAX_C  = 4'(MAX_TRIES);

    localparam logic [3:0] K_ENTER = 4'd10;
    localparam logic [3:0] K_BACK  = 4'd11;
    localparam logic [3:0] K_CLEAR = 4'd12;

    typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

    state_t              state_q, state_d;
    logic [4*NDIG-1:0]   data_q, data_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [3:0]          cur_q, cur_d;
    logic [3:0]          tries_q, tries_d;
    logic                commit_q, commit_d;
    logic [4*NDIG-1:0]   guess_q, guess_d;
    logic                locked_q, locked_d;

    logic                one_hot;
    logic [3:0]          code;

    // Decode the key vector: exactly-one-bit detection and the index of the set bit
    always_comb begin
        one_hot = (key != 16'd0) && ((key & (key - 16'd1)) == 16'd0);
        code    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key[i]) code = 4'(i);
        end
    end

    // Next-state and next-output logic; a press only acts on the IDLE->HOLD transition
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        tries_d  = tries_q;
        commit_d = 1'b0;
        guess_d  = guess_q;
        locked_d = locked_q;
        case (state_q)
            IDLE: begin
                if (key != 16'd0) begin
                    state_d = HOLD;
                    if (one_hot) begin
                        if (code <= 4'd9) begin
                            if (cnt_q < NDIG_C) begin
                                data_d = {data_q[4*NDIG-5:0], code};
                                cnt_d  = cnt_q + 2'd1;
                                cur_d  = code;
                            end
                        end else if (code == K_BACK) begin
                            if (cnt_q != 2'd0) begin
                                data_d = data_q >> 4;
                                cnt_d  = cnt_q - 2'd1;
                                cur_d  = code;
                            end
                        end else if (code == K_CLEAR) begin
                            data_d = '0;
                            cnt_d  = 2'd0;
                            cur_d  = code;
                        end else if (code == K_ENTER) begin
                            if (cnt_q != 2'd0) begin
                                guess_d  = data_q;
                                commit_d = 1'b1;
                                tries_d  = (tries_q == MAX_C) ? tries_q : tries_q + 4'd1;
                                data_d   = '0;
                                cnt_d    = 2'd0;
                                cur_d    = code;
                                if (tries_q + 4'd1 == MAX_C) locked_d = 1'b1;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (key == 16'd0) state_d = locked_q ? LOCK : IDLE;
            end
            LOCK: begin
                if (one_hot && code == K_CLEAR) begin
                    data_d   = '0;
                    cnt_d    = 2'd0;
                    tries_d  = 4'd0;
                    locked_d = 1'b0;
                    cur_d    = code;
                    state_d  = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial entry immediately
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            cnt_q    <= 2'd0;
            cur_q    <= 4'd0;
            tries_q  <= 4'd0;
            commit_q <= 1'b0;
            guess_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            tries_q  <= tries_d;
            commit_q <= commit_d;
            guess_q  <= guess_d;
            locked_q <= locked_d;
        end
    end

    assign data      = data_q;
    assign digit_cnt = cnt_q;
    assign cur_digit = cur_q;
    assign tries     = tries_q;
    assign commit    = commit_q;
    assign guess     = guess_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed checks of entry, backspace, commit, hold, lockout and async reset
module tb_keypad_entry_ctrl;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] key = 16'd0;
    logic [11:0] data;
    logic [1:0]  digit_cnt;
    logic [3:0]  cur_digit;
    logic [3:0]  tries;
    logic        commit;
    logic [11:0] guess;
    logic        locked;

    int errors = 0;
    int checks = 0;
    int ncommit = 0;

    localparam logic [15:0] KA = 16'h0400;
    localparam logic [15:0] KB = 16'h0800;
    localparam logic [15:0] KC = 16'h1000;
    localparam logic [15:0] KD = 16'h2000;

    keypad_entry_ctrl #(.NDIG(3), .MAX_TRIES(9)) dut (
        .clk(clk), .RSTn(RSTn), .key(key), .data(data), .digit_cnt(digit_cnt),
        .cur_digit(cur_digit), .tries(tries), .commit(commit), .guess(guess), .locked(locked)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (commit === 1'b1) ncommit++;

    function automatic logic [15:0] kd(input int d);
        logic [15:0] v;
        v = 16'd1 << d;
        return v;
    endfunction

    task automatic press(input logic [15:0] k, input int hold);
        key = k;
        repeat (hold) @(negedge clk);
        key = 16'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", {data, digit_cnt, cur_digit, tries, commit, guess, locked}, 32'd0);
        RSTn = 1'b1;
        @(negedge clk);
        chk("reset_idle_out", {data, digit_cnt, cur_digit, tries, commit, guess, locked}, 32'd0);
    endtask

    task automatic test_digits;
        press(kd(4), 2);
        press(kd(2), 2);
        press(kd(7), 2);
        chk("digits_data", 32'(data), 32'h427);
        chk("digits_cnt", 32'(digit_cnt), 32'd3);
        chk("digits_cur", 32'(cur_digit), 32'd7);
    endtask

    task automatic test_full_back;
        press(kd(9), 2);
        chk("full_data", 32'(data), 32'h427);
        chk("full_cur", 32'(cur_digit), 32'd7);
        press(KB, 2);
        chk("back_data", 32'(data), 32'h042);
        chk("back_cnt", 32'(digit_cnt), 32'd2);
        chk("back_cur", 32'(cur_digit), 32'd11);
    endtask

    task automatic test_commit;
        int c0;
        c0 = ncommit;
        key = KA;
        @(negedge clk);
        chk("commit_pulse", 32'(commit), 32'd1);
        chk("commit_guess", 32'(guess), 32'h042);
        chk("commit_tries", 32'(tries), 32'd1);
        chk("commit_data", {16'(data), 16'(digit_cnt)}, 32'd0);
        @(negedge clk);
        chk("commit_one_cycle", 32'(commit), 32'd0);
        repeat (5) @(negedge clk);
        key = 16'd0;
        repeat (3) @(negedge clk);
        chk("commit_count", 32'(ncommit - c0), 32'd1);
        c0 = ncommit;
        press(KA, 3);
        chk("empty_enter_commit", 32'(ncommit - c0), 32'd0);
        chk("empty_enter_tries", 32'(tries), 32'd1);
        chk("empty_enter_cur", 32'(cur_digit), 32'd10);
    endtask

    task automatic test_hold;
        press(kd(5), 1000);
        chk("hold_data", 32'(data), 32'h005);
        chk("hold_cnt", 32'(digit_cnt), 32'd1);
        press(kd(3) | kd(6), 3);
        chk("multi_data", 32'(data), 32'h005);
        chk("multi_cur", 32'(cur_digit), 32'd5);
        press(KD, 2);
        chk("keyd_ignored", {16'(data), 12'(cur_digit), 4'(digit_cnt)}, {16'h005, 12'd5, 4'd1});
    endtask

    task automatic test_clear;
        press(KC, 2);
        chk("clear_data", {16'(data), 16'(digit_cnt)}, 32'd0);
        chk("clear_tries", 32'(tries), 32'd1);
        chk("clear_cur", 32'(cur_digit), 32'd12);
    endtask

    task automatic test_back_to_back;
        key = kd(1);
        @(negedge clk);
        key = 16'd0;
        @(negedge clk);
        @(negedge clk);
        key = kd(8);
        @(negedge clk);
        key = 16'd0;
        repeat (2) @(negedge clk);
        chk("b2b_data", 32'(data), 32'h018);
        press(KC, 1);
    endtask

    task automatic test_lock;
        int c0;
        c0 = ncommit;
        for (int i = 0; i < 8; i++) begin
            press(kd(1), 2);
            press(KA, 2);
        end
        chk("lock_commits", 32'(ncommit - c0), 32'd8);
        chk("lock_tries", 32'(tries), 32'd9);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_guess", 32'(guess), 32'h001);
        press(kd(3), 2);
        chk("lock_digit_ignored", {16'(data), 16'(digit_cnt)}, 32'd0);
        c0 = ncommit;
        press(KA, 2);
        chk("lock_enter_ignored", {16'(ncommit - c0), 12'(tries), 4'(cur_digit)}, {16'd0, 12'd9, 4'd10});
        press(KC, 2);
        chk("unlock_tries", 32'(tries), 32'd0);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_cur", 32'(cur_digit), 32'd12);
        press(kd(2), 2);
        chk("unlock_idle_data", 32'(data), 32'h002);
    endtask

    task automatic test_async_reset;
        press(KC, 1);
        press(kd(3), 2);
        press(kd(1), 2);
        chk("pre_reset_data", 32'(data), 32'h031);
        #3 RSTn = 1'b0;
        #1;
        chk("async_reset_out", {data, digit_cnt, cur_digit, tries, commit, guess, locked}, 32'd0);
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        press(kd(8), 2);
        chk("post_reset_data", 32'(data), 32'h008);
        chk("post_reset_cnt", 32'(digit_cnt), 32'd1);
    endtask

    initial begin
        test_reset;
        test_digits;
        test_full_back;
        test_commit;
        test_hold;
        test_clear;
        test_back_to_back;
        test_lock;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
